// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its per-digit slice.
package bcd_down_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam int          DIGIT_W = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   // Clamp an out-of-range nibble to the largest legal BCD digit.
   function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of the countdown: synchronous saturating load, decrement on
// borrow_in, and borrow_out when the digit wraps from 0 to 9.
module bcd_digit_dn
   import bcd_down_timer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_digit,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] digit,
   output logic               borrow_out
);

   logic [DIGIT_W-1:0] digit_reg;
   logic [DIGIT_W-1:0] digit_next;

   always_comb begin
      digit_next = digit_reg;
      if (load) begin
         digit_next = sat_digit(load_digit);
      end else if (borrow_in) begin
         digit_next = (digit_reg == '0) ? BCD_MAX : digit_reg - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_reg <= '0;
      end else begin
         digit_reg <= digit_next;
      end
   end

   assign digit      = digit_reg;
   assign borrow_out = borrow_in & ~load & (digit_reg == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with one-cycle expiry pulse.
// Optional periodic mode: define BCD_TIMER_AUTO_RELOAD_EN to reload the last preset on expiry.
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic                      load,
   input  logic [DIGIT_W*DIGITS-1:0] load_val,
   input  logic                      dec,
   output logic [DIGIT_W*DIGITS-1:0] count,
   output logic                      zero,
   output logic                      done,
   output logic                      running
);

   localparam int W = DIGIT_W * DIGITS;

   state_t         state_reg;
   state_t         state_next;
   logic           done_reg;
   logic [W-1:0]   sanitized;
   logic [W-1:0]   load_data;
   logic           digit_load;
   logic [DIGITS:0] borrow;
   logic           borrow_unused;
   logic           acc_load;
   logic           acc_dec;
   logic           expiry;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign sanitized[gi*DIGIT_W +: DIGIT_W] = sat_digit(load_val[gi*DIGIT_W +: DIGIT_W]);

         bcd_digit_dn u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (digit_load),
            .load_digit (load_data[gi*DIGIT_W +: DIGIT_W]),
            .borrow_in  (borrow[gi]),
            .digit      (count[gi*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow[gi+1])
         );
      end
   endgenerate

   // The top digit can never borrow out: RUN never holds a zero count.
   assign borrow_unused = borrow[DIGITS];

   assign zero     = (count == '0);
   assign acc_load = ena & load;
   assign acc_dec  = ena & dec & ~load & (state_reg == RUN) & ~zero;
   assign expiry   = acc_dec & (count == W'(1));

`ifdef BCD_TIMER_AUTO_RELOAD_EN
   logic [W-1:0] reload_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reload_reg <= '0;
      end else if (acc_load) begin
         reload_reg <= sanitized;
      end
   end

   // Expiry reuses the digit load path to restart from the stored preset.
   assign digit_load = acc_load | expiry;
   assign load_data  = acc_load ? load_val : reload_reg;
   assign borrow[0]  = acc_dec & ~expiry;
`else
   assign digit_load = acc_load;
   assign load_data  = load_val;
   assign borrow[0]  = acc_dec;
`endif

   always_comb begin
      state_next = state_reg;
      if (acc_load) begin
         state_next = (sanitized != '0) ? RUN : IDLE;
      end else if (expiry) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         state_next = RUN;
`else
         state_next = EXPIRED;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= expiry;
      end
   end

   assign done    = done_reg;
   assign running = (state_reg == RUN);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed and randomized check of bcd_down_timer against an integer-valued reference model.
module tb_bcd_down_timer;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_EXP  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;
   logic        dec = 1'b0;
   logic [15:0] count;
   logic        zero;
   logic        done;
   logic        running;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain integers for the count and reload value.
   int m_count = 0;
   int m_reload = 0;
   int m_state = M_IDLE;
   bit m_done = 1'b0;

   bcd_down_timer #(.DIGITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .load     (load),
      .load_val (load_val),
      .dec      (dec),
      .count    (count),
      .zero     (zero),
      .done     (done),
      .running  (running)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int preset_value(input logic [15:0] lv);
      int v;
      int scale;
      int d;
      v = 0;
      scale = 1;
      for (int i = 0; i < 4; i++) begin
         d = int'(lv[i*4 +: 4]);
         if (d > 9) d = 9;
         v = v + d * scale;
         scale = scale * 10;
      end
      return v;
   endfunction

   task automatic model_step(input logic e, input logic l, input logic [15:0] lv, input logic d);
      m_done = 1'b0;
      if (e) begin
         if (l) begin
            m_count  = preset_value(lv);
            m_reload = m_count;
            m_state  = (m_count != 0) ? M_RUN : M_IDLE;
         end else if (d && m_state == M_RUN) begin
            if (m_count == 1) begin
               m_done = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
               m_count = m_reload;
`else
               m_count = 0;
               m_state = M_EXP;
`endif
            end else begin
               m_count = m_count - 1;
            end
         end
      end
   endtask

   task automatic model_reset();
      m_count = 0;
      m_reload = 0;
      m_state = M_IDLE;
      m_done = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [15:0] exp_count;
      exp_count = to_bcd(m_count);
      vectors += 4;
      assert (count === exp_count) else begin
         miscompares++;
         $error("FAIL %s count got %h expected %h", tag, count, exp_count);
      end
      assert (zero === (m_count == 0)) else begin
         miscompares++;
         $error("FAIL %s zero got %b expected %b", tag, zero, (m_count == 0));
      end
      assert (done === m_done) else begin
         miscompares++;
         $error("FAIL %s done got %b expected %b", tag, done, m_done);
      end
      assert (running === (m_state == M_RUN)) else begin
         miscompares++;
         $error("FAIL %s running got %b expected %b", tag, running, (m_state == M_RUN));
      end
   endtask

   task automatic step(input logic e, input logic l, input logic [15:0] lv, input logic d,
                       input string tag);
      ena = e;
      load = l;
      load_val = lv;
      dec = d;
      @(posedge clk);
      model_step(e, l, lv, d);
      #1;
      check_all(tag);
   endtask

   // Reset lands mid-cycle so the check proves it acts without a clock edge.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [15:0] lv;
      #3;
      check_all("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      step(1, 1, 16'h0003, 0, "load3");
      step(1, 0, 16'h0000, 1, "dec3_a");
      step(1, 0, 16'h0000, 1, "dec3_b");
      step(1, 0, 16'h0000, 1, "dec3_expire");
      step(1, 0, 16'h0000, 1, "after_expire");
      step(1, 0, 16'h0000, 1, "after_expire2");

      step(1, 1, 16'h1000, 0, "load1000");
      step(1, 0, 16'h0000, 1, "ripple");

      step(1, 1, 16'h00A5, 0, "saturate");
      step(1, 1, 16'hFFFF, 0, "saturate_all");
      step(1, 1, 16'h0000, 0, "load_zero");
      step(1, 0, 16'h0000, 1, "dec_idle");

      step(1, 1, 16'h0042, 1, "load_dec");
      step(0, 0, 16'h0000, 1, "ena_off_a");
      step(0, 1, 16'h0011, 1, "ena_off_b");
      step(1, 0, 16'h0000, 1, "dec_b2b_a");
      step(1, 0, 16'h0000, 1, "dec_b2b_b");

      step(1, 1, 16'h0057, 0, "load57");
      step(1, 0, 16'h0000, 1, "dec57");
      async_reset("rst_mid");
      step(1, 0, 16'h0000, 1, "dec_after_rst");

      step(1, 1, 16'h0001, 0, "load1");
      step(0, 0, 16'h0000, 1, "hold1");
      step(1, 0, 16'h0000, 1, "expire1");
      step(0, 0, 16'h0000, 0, "done_clear");

`ifdef BCD_TIMER_AUTO_RELOAD_EN
      step(1, 1, 16'h0002, 0, "ar_load2");
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 16'h0000, 1, "ar_dec");
      end
`endif

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 2))
            0: lv = 16'($urandom);
            1: lv = 16'($urandom_range(0, 20));
            default: lv = {8'h00, 4'($urandom_range(0, 3)), 4'($urandom)};
         endcase
         if ($urandom_range(0, 79) == 0) begin
            async_reset("rand_rst");
         end
         step(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 8), lv,
              ($urandom_range(0, 99) < 70), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
